// File: rtl/result_sched.sv
// ---------------------------------------------------------------------------
// result_sched
//   Sequencer for the argmax classification stage that follows the final
//   dense layer. A start pulse latches the score base address and enables
//   the classifier until it reports STOP. The 4-bit class index is then
//   captured and held, and a one-cycle done pulse is raised. A watchdog
//   aborts a job whose classifier never finishes. The block also owns the
//   single score-memory read port and shares it between the classifier
//   (during a job) and a host/debug readback requester (while idle).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, memstart_in       job launch pulse and score base address
//   res_enable/res_memstartp classifier enable and latched base address
//   res_stop/res_result      classifier finished / argmax index
//   res_re/res_addr          classifier read request
//   host_req/host_addr       host read request, host_gnt grant
//   mem_re/mem_addr          arbitrated score-memory read port
//   busy, done               job in flight, end-of-job pulse
//   result_out/result_valid  last captured class and its qualifier
//   timeout_err, overrun     sticky error flags
// ---------------------------------------------------------------------------
module result_sched #(
  parameter int SIZE_address_pix = 13,
  parameter int TIMEOUT          = 32,
  parameter int CNT_W            = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SIZE_address_pix-1:0] memstart_in,
  output logic                        res_enable,
  output logic [SIZE_address_pix-1:0] res_memstartp,
  input  logic                        res_stop,
  input  logic [3:0]                  res_result,
  input  logic                        res_re,
  input  logic [SIZE_address_pix-1:0] res_addr,
  input  logic                        host_req,
  input  logic [SIZE_address_pix-1:0] host_addr,
  output logic                        host_gnt,
  output logic                        mem_re,
  output logic [SIZE_address_pix-1:0] mem_addr,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  result_out,
  output logic                        result_valid,
  output logic                        timeout_err,
  output logic                        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] counter;

  // Next-state logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     state_nxt = RUN;
      RUN:     if (res_stop || (counter == CNT_LAST)) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered job outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= '0;
      res_enable    <= 1'b0;
      res_memstartp <= '0;
      done          <= 1'b0;
      result_out    <= 4'd0;
      result_valid  <= 1'b0;
      timeout_err   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      // A start is only accepted in IDLE; anything else is flagged.
      if (start && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            res_memstartp <= memstart_in;
            result_valid  <= 1'b0;
            timeout_err   <= 1'b0;
          end
        end
        ARM: begin
          // Base address has been stable for a cycle; now enable.
          res_enable <= 1'b1;
          counter    <= '0;
        end
        RUN: begin
          if (counter != CNT_LAST) counter <= counter + 1'b1;
          // done is raised on entry to FLUSH so it is high for exactly the
          // FLUSH cycle, alongside the freshly captured result.
          if (res_stop) begin
            result_out   <= res_result;
            result_valid <= 1'b1;
            res_enable   <= 1'b0;
            done         <= 1'b1;
          end else if (counter == CNT_LAST) begin
            res_enable  <= 1'b0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end
        end
        default: ;  // FLUSH: enable already low so the classifier clears
      endcase
    end
  end

  // Read-port arbitration: the classifier owns the port for the whole job,
  // the host only while idle. A stalled host simply keeps requesting.
  always_comb begin
    busy     = (state != IDLE);
    host_gnt = 1'b0;
    mem_re   = res_re;
    mem_addr = res_addr;
    if (state == IDLE) begin
      host_gnt = host_req;
      mem_re   = host_req;
      mem_addr = host_addr;
    end
  end

endmodule

// File: tb/tb_result_sched.sv
// ---------------------------------------------------------------------------
// tb_result_sched
//   Self-checking bench for result_sched. A classifier model drives the
//   res_* inputs; a job-timeline reference model (edges elapsed since an
//   accepted start) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_result_sched;

  localparam int AW      = 13;
  localparam int TIMEOUT = 32;
  localparam int CNT_W   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] memstart_in = '0;
  logic          res_enable;
  logic [AW-1:0] res_memstartp;
  logic          res_stop;
  logic [3:0]    res_result;
  logic          res_re;
  logic [AW-1:0] res_addr;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          host_gnt;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic          busy;
  logic          done;
  logic [3:0]    result_out;
  logic          result_valid;
  logic          timeout_err;
  logic          overrun;

  int n_assert = 0;
  int n_fail   = 0;

  result_sched #(
    .SIZE_address_pix (AW),
    .TIMEOUT          (TIMEOUT),
    .CNT_W            (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .memstart_in   (memstart_in),
    .res_enable    (res_enable),
    .res_memstartp (res_memstartp),
    .res_stop      (res_stop),
    .res_result    (res_result),
    .res_re        (res_re),
    .res_addr      (res_addr),
    .host_req      (host_req),
    .host_addr     (host_addr),
    .host_gnt      (host_gnt),
    .mem_re        (mem_re),
    .mem_addr      (mem_addr),
    .busy          (busy),
    .done          (done),
    .result_out    (result_out),
    .result_valid  (result_valid),
    .timeout_err   (timeout_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Stimulus plan for the next accepted job.
  int         plan_stop = 13;
  logic [3:0] plan_res  = 4'd0;

  // Reference model: job timeline. job = edges since the accepted start
  // (-1 when idle). 0 = setup, 1..k_end+1 = enabled, k_end+2 = flush.
  int            job   = -1;
  int            k_end = 0;
  int            m_stop = 1000;
  logic [3:0]    m_res = 4'd0;
  logic [AW-1:0] m_base = '0;
  logic          m_rv = 1'b0, m_terr = 1'b0, m_ovr = 1'b0;
  logic [3:0]    m_rout = 4'd0;

  always @(posedge clk) begin
    if (rst) begin
      job    <= -1;
      m_rv   <= 1'b0;
      m_terr <= 1'b0;
      m_ovr  <= 1'b0;
      m_rout <= 4'd0;
      m_base <= '0;
    end else begin
      if (job >= 0) begin
        if (job + 1 == k_end + 2) begin
          if (m_stop <= TIMEOUT - 1) begin
            m_rv   <= 1'b1;
            m_rout <= m_res;
          end else begin
            m_terr <= 1'b1;
          end
        end
        job <= (job + 1 == k_end + 3) ? -1 : job + 1;
      end
      if (start) begin
        if (job >= 0) begin
          m_ovr <= 1'b1;
        end else begin
          job    <= 0;
          m_base <= memstart_in;
          m_stop <= plan_stop;
          m_res  <= plan_res;
          k_end  <= (plan_stop < TIMEOUT - 1) ? plan_stop : TIMEOUT - 1;
          m_rv   <= 1'b0;
          m_terr <= 1'b0;
        end
      end
    end
  end

  // Classifier model: counts enabled edges, raises STOP after m_stop of
  // them, reads base+count while still working.
  int cls_cnt = 0;
  always @(posedge clk) begin
    if (rst || !res_enable) cls_cnt <= 0;
    else                    cls_cnt <= cls_cnt + 1;
  end
  assign res_stop   = res_enable && (cls_cnt >= m_stop);
  assign res_re     = res_enable && (cls_cnt < m_stop);
  assign res_addr   = res_memstartp + AW'(cls_cnt);
  assign res_result = res_stop ? m_res : ~m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic          e_busy, e_en, e_done, e_re;
    logic [AW-1:0] e_addr;
    e_busy = (job >= 0);
    e_en   = (job >= 1) && (job <= k_end + 1);
    e_done = (job == k_end + 2);
    e_re   = e_busy ? (e_en && (job - 1 < m_stop)) : host_req;
    check("busy",          32'(busy),          32'(e_busy));
    check("res_enable",    32'(res_enable),    32'(e_en));
    check("done",          32'(done),          32'(e_done));
    check("result_valid",  32'(result_valid),  32'(m_rv));
    check("result_out",    32'(result_out),    32'(m_rout));
    check("timeout_err",   32'(timeout_err),   32'(m_terr));
    check("overrun",       32'(overrun),       32'(m_ovr));
    check("res_memstartp", 32'(res_memstartp), 32'(m_base));
    check("host_gnt",      32'(host_gnt),      32'(!e_busy && host_req));
    check("mem_re",        32'(mem_re),        32'(e_re));
    if (!e_busy) begin
      check("mem_addr_host", 32'(mem_addr), 32'(host_addr));
    end else if (e_re) begin
      e_addr = m_base + AW'(job - 1);
      check("mem_addr_cls", 32'(mem_addr), 32'(e_addr));
    end
  endtask

  // Check the current cycle (inputs already applied), then advance one clock.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input logic [AW-1:0] b, input int s, input logic [3:0] r);
    plan_stop   = s;
    plan_res    = r;
    memstart_in = b;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i = 0;
    while ((job >= 0) && (i < bound)) begin
      tick();
      i++;
    end
    check("wait_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();

    // Nominal job: base 100, STOP after 13 enabled cycles, class 7
    run_job(13'd100, 13, 4'd7);
    wait_idle(60);
    tick();
    tick();

    // Classifier never stops: watchdog abort
    run_job(13'd200, 1000, 4'd3);
    wait_idle(60);
    tick();

    // Host request held across a job, asserted in the same cycle as start
    host_req  = 1'b1;
    host_addr = 13'd5;
    run_job(13'd300, 9, 4'd12);
    wait_idle(60);
    tick();
    host_req = 1'b0;
    tick();

    // Second start during RUN is ignored and flagged
    run_job(13'd400, 13, 4'd2);
    repeat (5) tick();
    plan_stop = 3;
    plan_res  = 4'd9;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(60);
    tick();

    // A start after done is accepted normally
    run_job(13'd500, 6, 4'd11);
    wait_idle(60);

    // Reset mid-RUN aborts without a done pulse; next job runs cleanly
    run_job(13'd600, 20, 4'd5);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run_job(13'd700, 13, 4'd1);
    wait_idle(60);

    // Start in the FLUSH cycle is still an overrun
    run_job(13'd800, 4, 4'd6);
    while ((job >= 0) && (job != k_end + 2)) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // STOP coincides with the last watchdog cycle: STOP wins
    run_job(13'd900, TIMEOUT - 1, 4'd13);
    wait_idle(60);

    // STOP one cycle too late: watchdog abort
    run_job(13'd1000, TIMEOUT, 4'd14);
    wait_idle(60);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      host_req    = 1'($urandom_range(0, 1));
      host_addr   = AW'($urandom);
      memstart_in = AW'($urandom);
      plan_stop   = int'($urandom_range(1, 40));
      plan_res    = 4'($urandom);
      start       = ($urandom_range(0, 5) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      tick();
    end
    start    = 1'b0;
    rst      = 1'b0;
    host_req = 1'b0;
    wait_idle(60);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/result_sched.md
Name: result_sched

Overview:
- Sequencer for the argmax classification stage that follows the final dense layer.
- On a start pulse it latches the score base address and enables the classifier until that unit reports STOP. It then captures the 4-bit class index and raises a done pulse with a held result.
- It owns the single score-memory read port and shares it between the classifier and a host/debug readback requester.
- A watchdog guards against a classifier that never finishes.

Parameters:
- SIZE_address_pix, 13, width of score-memory addresses.
- TIMEOUT, 32, maximum RUN cycles before abort; must be >13 (the classifier needs 13 enabled cycles).
- CNT_W, 6, width of the watchdog counter; 2^CNT_W must exceed TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: final layer has written class scores
- memstart_in  in  SIZE_address_pix  base address of the 11 class scores, sampled with start
- res_enable  out  1  enable to the classifier
- res_memstartp  out  SIZE_address_pix  latched base address to the classifier
- res_stop  in  1  classifier finished
- res_result  in  4  classifier argmax index
- res_re  in  1  classifier read enable
- res_addr  in  SIZE_address_pix  classifier read address
- host_req  in  1  host requests the read port
- host_addr  in  SIZE_address_pix  host read address
- host_gnt  out  1  host owns the port this cycle
- mem_re  out  1  read enable to score memory
- mem_addr  out  SIZE_address_pix  read address to score memory
- busy  out  1  high in ARM/RUN/FLUSH
- done  out  1  one-cycle pulse at end of every job (success or abort)
- result_out  out  4  last captured class
- result_valid  out  1  result_out is valid
- timeout_err  out  1  sticky: last job aborted by watchdog
- overrun  out  1  sticky: start received while not IDLE

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE.
  - res_enable, host_gnt, busy, done, result_valid, timeout_err, overrun all 0.
  - result_out=0, res_memstartp=0, counter=0.
  - rst mid-job aborts immediately: res_enable=0 the next cycle, no done pulse.
- States:
  - IDLE, start=1: latch memstart_in into res_memstartp; clear result_valid and timeout_err; go to ARM. busy=1 from the next cycle.
  - ARM: res_enable<=1, counter<=0, go to RUN. This is a one-cycle setup so the address is stable before enable.
  - RUN, each cycle: res_enable stays 1, counter increments.
    - If res_stop=1: result_out<=res_result, result_valid<=1, res_enable<=0, go to FLUSH.
    - Else if counter==TIMEOUT-1: res_enable<=0, timeout_err<=1, result_valid stays 0, go to FLUSH.
    - res_stop takes priority over timeout in the same cycle.
  - FLUSH: res_enable=0 for exactly one cycle so the classifier clears its internal step count. done<=1 (single cycle). Go to IDLE.
- start outside IDLE, including the cycle FLUSH→IDLE: ignored, overrun<=1 (sticky until rst).
- Read-port arbitration is combinational:
  - In ARM/RUN/FLUSH the classifier owns the port: mem_re=res_re, mem_addr=res_addr, host_gnt=0.
  - In IDLE: host_gnt=host_req, mem_re=host_req, mem_addr=host_addr.
  - Host requests during a job are stalled, never queued or dropped; the host holds host_req until host_gnt.
  - host_req and start in the same IDLE cycle: host granted that cycle, classifier owns the port from ARM onward.
- Nominal latency:
  - start at edge 0; ARM at 1; res_enable first high at edge 2.
  - Classifier STOP after 13 enabled edges, visible at edge 14.
  - Capture at edge 15 (result_valid=1, FLUSH); done high during cycle 15→16; IDLE at 16.
- result_out and result_valid hold until the next accepted start.
- Counter saturates at TIMEOUT-1 and never wraps.

Test Plan:
- Reset then start with memstart_in=100; classifier model returns 7 with STOP 13 enabled cycles later → mem_addr sequence 100..112, result_out=7, result_valid=1, done one pulse, busy low after 16 cycles, timeout_err=0.
- Classifier model never raises STOP, TIMEOUT=32 → res_enable low after 32 RUN cycles, timeout_err=1, result_valid=0, done one pulse, state IDLE.
- host_req held with host_addr=5 across a job → host_gnt=0 throughout ARM/RUN/FLUSH, then host_gnt=1 with mem_addr=5 in the first IDLE cycle.
- Second start pulse in RUN → ignored, overrun=1, and the first job completes with correct result; a start after done is accepted normally.
- rst asserted mid-RUN → next cycle res_enable=0, busy=0, result_valid=0, no done pulse; a following start runs cleanly.
- res_stop and timeout in the same cycle (STOP at cycle TIMEOUT-1) → result captured, timeout_err=0.
